// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : 640x480@60 timing constants, derived totals and pattern colours.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_SQ_SIZE  = 32;

    localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_H_ACT_END   = VGA_H_ACT_START + VGA_H_ACTIVE;
    localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_V_ACT_END   = VGA_V_ACT_START + VGA_V_ACTIVE;

    // Counter and coordinate width; holds totals up to 1023.
    localparam int CNT_W = 10;

    localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
    localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
    localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
    localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;
    localparam logic [15:0] COLOR_RED     = 16'hF800;
    localparam logic [15:0] COLOR_BLUE    = 16'h001F;
    localparam logic [15:0] COLOR_BLACK   = 16'h0000;
    localparam logic [15:0] COLOR_SQUARE  = 16'h8410;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = COLOR_WHITE;
            3'd1:    bar_color = COLOR_YELLOW;
            3'd2:    bar_color = COLOR_CYAN;
            3'd3:    bar_color = COLOR_GREEN;
            3'd4:    bar_color = COLOR_MAGENTA;
            3'd5:    bar_color = COLOR_RED;
            3'd6:    bar_color = COLOR_BLUE;
            default: bar_color = COLOR_BLACK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : Pixel enable, h/v counters, sync levels and active-area x/y.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_active,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_frame_end
);

    localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_ACT_START = H_SYNC + H_BACK;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    logic             r_pix_en;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_h_act;
    logic             w_v_act;

    assign w_h_last = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == CNT_W'(V_TOTAL - 1));

    // The port named rst_n is an active-high asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_hsync_n   = (r_h_cnt >= CNT_W'(H_SYNC));
    assign o_vsync_n   = (r_v_cnt >= CNT_W'(V_SYNC));
    assign w_h_act     = (r_h_cnt >= CNT_W'(H_ACT_START)) && (r_h_cnt < CNT_W'(H_ACT_END));
    assign w_v_act     = (r_v_cnt >= CNT_W'(V_ACT_START)) && (r_v_cnt < CNT_W'(V_ACT_END));
    assign o_active    = w_h_act && w_v_act;
    assign o_x         = r_h_cnt - CNT_W'(H_ACT_START);
    assign o_y         = r_v_cnt - CNT_W'(V_ACT_START);
    assign o_frame_end = r_pix_en && w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: rtl/vga_plus.sv
`default_nettype none
// ============================================================================
// Module   : vga_plus
// Brief    : VGA colour-bar source with a bouncing grey square, RGB565 out.
// Revision : 1.0 - initial release
// ============================================================================
module vga_plus
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT,
    parameter int SQ_SIZE  = VGA_SQ_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int SUM_W = CNT_W + 1;
    // Positions one step short of each limit: the move that lands on the limit flips direction.
    localparam logic [CNT_W-1:0] X_TURN = CNT_W'(H_ACTIVE - SQ_SIZE - 1);
    localparam logic [CNT_W-1:0] Y_TURN = CNT_W'(V_ACTIVE - SQ_SIZE - 1);

    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_active;
    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_y;
    logic             w_frame_end;
    logic [2:0]       w_bar;
    logic             w_in_sq;
    logic [15:0]      w_pixel;

    logic [CNT_W-1:0] r_sq_x;
    logic [CNT_W-1:0] r_sq_y;
    logic             r_dx;
    logic             r_dy;

    vga_timing #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_hsync_n   (w_hsync_n),
        .o_vsync_n   (w_vsync_n),
        .o_active    (w_active),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_frame_end (w_frame_end)
    );

    // Bar index as x / BAR_W, built from threshold compares instead of a divider.
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_x >= CNT_W'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    assign w_in_sq = (w_x >= r_sq_x) && ({1'b0, w_x} < ({1'b0, r_sq_x} + SUM_W'(SQ_SIZE))) &&
                     (w_y >= r_sq_y) && ({1'b0, w_y} < ({1'b0, r_sq_y} + SUM_W'(SQ_SIZE)));

    always_comb begin
        w_pixel = COLOR_BLACK;
        if (w_active) begin
            w_pixel = w_in_sq ? COLOR_SQUARE : bar_color(w_bar);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sq_x <= '0;
            r_sq_y <= '0;
            r_dx   <= 1'b1;
            r_dy   <= 1'b1;
        end else if (w_frame_end) begin
            if (r_dx) begin
                r_sq_x <= r_sq_x + CNT_W'(1);
                if (r_sq_x == X_TURN) r_dx <= 1'b0;
            end else begin
                r_sq_x <= r_sq_x - CNT_W'(1);
                if (r_sq_x == CNT_W'(1)) r_dx <= 1'b1;
            end
            if (r_dy) begin
                r_sq_y <= r_sq_y + CNT_W'(1);
                if (r_sq_y == Y_TURN) r_dy <= 1'b0;
            end else begin
                r_sq_y <= r_sq_y - CNT_W'(1);
                if (r_sq_y == CNT_W'(1)) r_dy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 16'h0000;
        end else begin
            hsync <= w_hsync_n;
            vsync <= w_vsync_n;
            rgb   <= w_pixel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_plus.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plus
// Brief    : Scoreboard bench: shrunk-timing instance checked every clk, plus a
//            full 640x480 instance for real line/frame sync timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plus;

    localparam int HS = 4, HB = 4, HA = 16, HF = 4;
    localparam int VS = 1, VB = 2, VA = 10, VF = 2;
    localparam int SQ = 4;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME_CLK = 2 * HT * VT;
    localparam int LX = HA - SQ;
    localparam int LY = VA - SQ;
    localparam int BW = HA / 8;
    localparam int N_FRAMES = 26;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hs_s, vs_s, hs_f, vs_f;
    logic [15:0] rgb_s, rgb_f;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   m_pix, m_h, m_v, m_frame;
    int   cyc;
    logic prev_hs, prev_vs;
    int   hs_f0, hs_r0, hs_f1, vs_f0, vs_r0;

    vga_plus #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SQ_SIZE(SQ)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .hsync (hs_s),
        .vsync (vs_s),
        .rgb   (rgb_s)
    );

    vga_plus u_full (
        .clk   (clk),
        .rst_n (rst_n),
        .hsync (hs_f),
        .vsync (vs_f),
        .rgb   (rgb_f)
    );

    always #10 clk = ~clk;

    // Bounce position after f frames: a triangle wave between 0 and lim.
    function automatic int tri_pos(input int f, input int lim);
        int r;
        r = f % (2 * lim);
        return (r <= lim) ? r : 2 * lim - r;
    endfunction

    function automatic logic [15:0] bar_ref(input int b);
        case (b)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string tag, input int at, input logic [17:0] obs, input logic [17:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h, expected %h", tag, at, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pix = 0; m_h = 0; m_v = 0; m_frame = 0;
        sb.delete();
        cyc = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        hs_f0 = -1; hs_r0 = -1; hs_f1 = -1; vs_f0 = -1; vs_r0 = -1;
    endtask

    task automatic push_expected();
        exp_t e;
        int   x, y, sx, sy;
        logic act;
        x   = m_h - (HS + HB);
        y   = m_v - (VS + VB);
        act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
        sx  = tri_pos(m_frame, LX);
        sy  = tri_pos(m_frame, LY);
        e.hs = (m_h >= HS);
        e.vs = (m_v >= VS);
        if (!act)
            e.rgb = 16'h0000;
        else if (x >= sx && x < sx + SQ && y >= sy && y < sy + SQ)
            e.rgb = 16'h8410;
        else
            e.rgb = bar_ref(x / BW);
        sb.push_back(e);
    endtask

    task automatic advance_model();
        if (m_pix == 1) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v = 0;
                    m_frame++;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        m_pix = 1 - m_pix;
    endtask

    task automatic track_full();
        cyc++;
        if (prev_hs && !hs_f) begin
            if (hs_f0 < 0) hs_f0 = cyc;
            else if (hs_f1 < 0) hs_f1 = cyc;
        end
        if (!prev_hs && hs_f && hs_r0 < 0) hs_r0 = cyc;
        if (prev_vs && !vs_f && vs_f0 < 0) vs_f0 = cyc;
        if (!prev_vs && vs_f && vs_r0 < 0) vs_r0 = cyc;
        prev_hs = hs_f;
        prev_vs = vs_f;
    endtask

    task automatic tick();
        exp_t e;
        push_expected();
        @(posedge clk);
        #1;
        advance_model();
        track_full();
        e = sb.pop_front();
        check("small_out", cyc, {hs_s, vs_s, rgb_s}, e);
        if (cyc <= 3300) check("full_blank_rgb", cyc, {2'b00, rgb_f}, 18'h0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_small"}, cyc, {hs_s, vs_s, rgb_s}, {2'b11, 16'h0000});
        check({tag, "_full"}, cyc, {hs_f, vs_f, rgb_f}, {2'b11, 16'h0000});
    endtask

    initial begin
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_hold");
        rst_n = 1'b0;

        for (int i = 0; i < N_FRAMES * FRAME_CLK; i++) tick();

        check("full_hsync_first_fall", 0, 18'(hs_f0), 18'd1);
        check("full_hsync_low", 0, 18'(hs_r0 - hs_f0), 18'd192);
        check("full_hsync_period", 0, 18'(hs_f1 - hs_f0), 18'd1600);
        check("full_vsync_first_fall", 0, 18'(vs_f0), 18'd1);
        check("full_vsync_low", 0, 18'(vs_r0 - vs_f0), 18'd3200);

        // Land mid-line, then reset asynchronously between clock edges.
        for (int i = 0; i < 37; i++) tick();
        rst_n = 1'b1;
        #1;
        check_reset("async_reset");
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset("reset_hold2");
        end
        rst_n = 1'b0;

        for (int i = 0; i < 2 * FRAME_CLK + 40; i++) tick();

        check("restart_hsync_first_fall", 0, 18'(hs_f0), 18'd1);
        check("restart_hsync_low", 0, 18'(hs_r0 - hs_f0), 18'd192);
        check("restart_hsync_period", 0, 18'(hs_f1 - hs_f0), 18'd1600);
        check("restart_vsync_first_fall", 0, 18'(vs_f0), 18'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
